// File: rtl/adder_tree_acc_if.sv
// Lane-sum / frame-integrator bus: samples in from the product stage, tree and frame results out.
interface adder_tree_acc_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PARALLEL   = 10,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned LEN_WIDTH  = 16
);
    localparam int unsigned TW = DATA_WIDTH + $clog2(PARALLEL);

    logic [DATA_WIDTH*PARALLEL-1:0] din;
    logic                           in_valid;
    logic                           sync_in;
    logic [LEN_WIDTH-1:0]           acc_len;
    logic [TW-1:0]                  tree_dout;
    logic                           tree_valid;
    logic [ACC_WIDTH-1:0]           acc_dout;
    logic                           acc_valid;
    logic                           ovf;

    modport master (
        output din, in_valid, sync_in, acc_len,
        input  tree_dout, tree_valid, acc_dout, acc_valid, ovf
    );

    modport slave (
        input  din, in_valid, sync_in, acc_len,
        output tree_dout, tree_valid, acc_dout, acc_valid, ovf
    );
endinterface

// File: rtl/adder_tree_acc.sv
// Pipelined pairwise adder tree over PARALLEL lanes feeding a frame integrator
// with programmable frame length, sync restart and saturating/wrapping overflow.
module adder_tree_acc #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PARALLEL   = 10,
    parameter int unsigned SIGNED     = 1,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned SATURATE   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    adder_tree_acc_if.slave   bus
);
    localparam int unsigned NS = $clog2(PARALLEL);
    localparam int unsigned TW = DATA_WIDTH + NS;
    localparam int unsigned L  = (PARALLEL == 1) ? 1 : NS;
    localparam int unsigned M  = ACC_WIDTH - 1;
    localparam bit          SX = (SIGNED != 0);

    function automatic int unsigned lanes_at(input int unsigned stage);
        int unsigned n;
        n = PARALLEL;
        for (int unsigned i = 0; i < stage; i++) n = (n + 1) / 2;
        return n;
    endfunction

    logic [TW-1:0] tree_sum;

    // Reduction tree: each stage halves the lane count and grows one bit
    generate
        if (PARALLEL == 1) begin : g_single
            logic [TW-1:0] sum_q;
            always_ff @(posedge clk) begin
                if (!rst_n) sum_q <= '0;
                else        sum_q <= bus.din;
            end
            assign tree_sum = sum_q;
        end else begin : g_tree
            for (genvar s = 0; s <= NS; s++) begin : g_stage
                localparam int unsigned N = lanes_at(s);
                localparam int unsigned W = DATA_WIDTH + s;
                logic [W-1:0] lane [N];
                if (s == 0) begin : g_in
                    for (genvar k = 0; k < N; k++) begin : g_k
                        assign lane[k] = bus.din[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                end else begin : g_add
                    localparam int unsigned NP = lanes_at(s - 1);
                    logic [W-1:0] lane_d [N];
                    for (genvar k = 0; k < N; k++) begin : g_k
                        logic [W-2:0] a;
                        assign a = g_stage[s-1].lane[2*k];
                        if (2*k + 1 < NP) begin : g_pair
                            logic [W-2:0] b;
                            assign b = g_stage[s-1].lane[2*k+1];
                            assign lane_d[k] = {SX & a[W-2], a} + {SX & b[W-2], b};
                        end else begin : g_odd
                            assign lane_d[k] = {SX & a[W-2], a};
                        end
                    end
                    always_ff @(posedge clk) begin
                        for (int unsigned k = 0; k < N; k++) begin
                            if (!rst_n) lane[k] <= '0;
                            else        lane[k] <= lane_d[k];
                        end
                    end
                end
            end
            assign tree_sum = g_stage[NS].lane[0];
        end
    endgenerate

    // Valid and sync ride alongside the tree data
    logic [L-1:0] vld_q, vld_d, sync_q, sync_d;
    logic         tree_valid, tree_sync;

    assign vld_d      = L'({vld_q, bus.in_valid});
    assign sync_d     = L'({sync_q, bus.sync_in});
    assign tree_valid = vld_q[L-1];
    assign tree_sync  = sync_q[L-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            sync_q <= '0;
        end else begin
            vld_q  <= vld_d;
            sync_q <= sync_d;
        end
    end

    logic [ACC_WIDTH-1:0] tree_ext, ext_mask;
    logic [ACC_WIDTH-1:0] sum_raw, sum_val, sat_val;
    logic                 sum_ovf, carry;

    assign ext_mask = ~ACC_WIDTH'({TW{1'b1}});
    assign tree_ext = ACC_WIDTH'(tree_sum) | ((SX && tree_sum[TW-1]) ? ext_mask : '0);

    logic [LEN_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d, len_new;
    logic [ACC_WIDTH-1:0] acc_q, acc_d, dout_q, dout_d;
    logic                 flag_q, flag_d, dvld_q, dvld_d, dovf_q, dovf_d;
    logic                 first, last;

    // Accumulator add with overflow detect and optional clamp
    always_comb begin
        carry   = 1'b0;
        sum_raw = '0;
        sum_ovf = 1'b0;
        sat_val = '1;
        if (SX) begin
            sum_raw = acc_q + tree_ext;
            sum_ovf = (acc_q[M] == tree_ext[M]) && (sum_raw[M] != acc_q[M]);
            sat_val = acc_q[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};
        end else begin
            {carry, sum_raw} = {1'b0, acc_q} + {1'b0, tree_ext};
            sum_ovf = carry;
        end
        sum_val = (sum_ovf && SATURATE != 0) ? sat_val : sum_raw;
    end

    assign len_new = (bus.acc_len == '0) ? LEN_WIDTH'(1) : bus.acc_len;

    // Frame integrator: sync or cnt==0 starts a frame, reaching len dumps it
    always_comb begin
        cnt_d  = cnt_q;
        len_d  = len_q;
        acc_d  = acc_q;
        flag_d = flag_q;
        dout_d = dout_q;
        dvld_d = 1'b0;
        dovf_d = dovf_q;
        first  = 1'b0;
        last   = 1'b0;
        if (tree_valid) begin
            first = tree_sync || (cnt_q == '0);
            if (first) begin
                len_d  = len_new;
                acc_d  = tree_ext;
                flag_d = 1'b0;
                last   = (len_new == LEN_WIDTH'(1));
            end else begin
                acc_d  = sum_val;
                flag_d = flag_q | sum_ovf;
                last   = (cnt_q == len_q - LEN_WIDTH'(1));
            end
            if (last) begin
                cnt_d  = '0;
                dout_d = acc_d;
                dvld_d = 1'b1;
                dovf_d = flag_d;
            end else begin
                cnt_d  = first ? LEN_WIDTH'(1) : cnt_q + LEN_WIDTH'(1);
            end
        end else if (tree_sync) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            len_q  <= '0;
            acc_q  <= '0;
            flag_q <= 1'b0;
            dout_q <= '0;
            dvld_q <= 1'b0;
            dovf_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            acc_q  <= acc_d;
            flag_q <= flag_d;
            dout_q <= dout_d;
            dvld_q <= dvld_d;
            dovf_q <= dovf_d;
        end
    end

    assign bus.tree_dout  = tree_sum;
    assign bus.tree_valid = tree_valid;
    assign bus.acc_dout   = dout_q;
    assign bus.acc_valid  = dvld_q;
    assign bus.ovf        = dovf_q;
endmodule

// File: tb/tb_adder_tree_acc.sv
// Directed bench for adder_tree_acc: main 10-lane signed instance, 12-bit saturating
// and wrapping variants, and a single-lane unsigned instance.
module tb_adder_tree_acc;
    typedef struct {
        longint val;
        bit     ovf;
        int     cyc;
    } dump_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [79:0] din;
    logic [7:0]  din_p1;
    logic        in_valid;
    logic        sync_in;
    logic [15:0] acc_len;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    dump_t       q_main[$], q_sat[$], q_wrap[$], q_p1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_tree_acc_if #(.DATA_WIDTH(8), .PARALLEL(10), .ACC_WIDTH(32), .LEN_WIDTH(16)) m_if ();
    adder_tree_acc_if #(.DATA_WIDTH(8), .PARALLEL(10), .ACC_WIDTH(12), .LEN_WIDTH(16)) s_if ();
    adder_tree_acc_if #(.DATA_WIDTH(8), .PARALLEL(10), .ACC_WIDTH(12), .LEN_WIDTH(16)) w_if ();
    adder_tree_acc_if #(.DATA_WIDTH(8), .PARALLEL(1),  .ACC_WIDTH(32), .LEN_WIDTH(16)) p_if ();

    adder_tree_acc #(.DATA_WIDTH(8), .PARALLEL(10), .SIGNED(1), .ACC_WIDTH(32),
                     .LEN_WIDTH(16), .SATURATE(1))
        u_main (.clk(clk), .rst_n(rst_n), .bus(m_if));
    adder_tree_acc #(.DATA_WIDTH(8), .PARALLEL(10), .SIGNED(1), .ACC_WIDTH(12),
                     .LEN_WIDTH(16), .SATURATE(1))
        u_sat (.clk(clk), .rst_n(rst_n), .bus(s_if));
    adder_tree_acc #(.DATA_WIDTH(8), .PARALLEL(10), .SIGNED(1), .ACC_WIDTH(12),
                     .LEN_WIDTH(16), .SATURATE(0))
        u_wrap (.clk(clk), .rst_n(rst_n), .bus(w_if));
    adder_tree_acc #(.DATA_WIDTH(8), .PARALLEL(1), .SIGNED(0), .ACC_WIDTH(32),
                     .LEN_WIDTH(16), .SATURATE(1))
        u_p1 (.clk(clk), .rst_n(rst_n), .bus(p_if));

    assign m_if.din = din;    assign m_if.in_valid = in_valid;
    assign m_if.sync_in = sync_in; assign m_if.acc_len = acc_len;
    assign s_if.din = din;    assign s_if.in_valid = in_valid;
    assign s_if.sync_in = sync_in; assign s_if.acc_len = acc_len;
    assign w_if.din = din;    assign w_if.in_valid = in_valid;
    assign w_if.sync_in = sync_in; assign w_if.acc_len = acc_len;
    assign p_if.din = din_p1; assign p_if.in_valid = in_valid;
    assign p_if.sync_in = sync_in; assign p_if.acc_len = acc_len;

    // Dump recorder, sampled mid-cycle
    always @(negedge clk) begin
        dump_t d;
        if (m_if.acc_valid) begin
            d.val = longint'($signed(m_if.acc_dout)); d.ovf = m_if.ovf; d.cyc = cyc;
            q_main.push_back(d);
        end
        if (s_if.acc_valid) begin
            d.val = longint'($signed(s_if.acc_dout)); d.ovf = s_if.ovf; d.cyc = cyc;
            q_sat.push_back(d);
        end
        if (w_if.acc_valid) begin
            d.val = longint'($signed(w_if.acc_dout)); d.ovf = w_if.ovf; d.cyc = cyc;
            q_wrap.push_back(d);
        end
        if (p_if.acc_valid) begin
            d.val = longint'(p_if.acc_dout); d.ovf = p_if.ovf; d.cyc = cyc;
            q_p1.push_back(d);
        end
    end

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        sync_in  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_uniform(input int v, input bit s);
        for (int k = 0; k < 10; k++) din[k*8 +: 8] = 8'(v);
        din_p1   = 8'(v);
        in_valid = 1'b1;
        sync_in  = s;
        tick();
    endtask

    task automatic send_alt();
        for (int k = 0; k < 10; k++) din[k*8 +: 8] = (k % 2 == 0) ? 8'h80 : 8'h7F;
        din_p1   = 8'h80;
        in_valid = 1'b1;
        sync_in  = 1'b0;
        tick();
    endtask

    task automatic clear_dumps();
        q_main.delete(); q_sat.delete(); q_wrap.delete(); q_p1.delete();
    endtask

    initial begin
        rst_n = 1'b0; din = '0; din_p1 = '0; in_valid = 1'b0; sync_in = 1'b0; acc_len = 16'd1;

        // Reset and tree latency
        idle(3);
        check_val("rst_tree_dout",  longint'(m_if.tree_dout), 0);
        check_val("rst_tree_valid", longint'(m_if.tree_valid), 0);
        check_val("rst_acc_dout",   longint'(m_if.acc_dout), 0);
        check_val("rst_acc_valid",  longint'(m_if.acc_valid), 0);
        check_val("rst_ovf",        longint'(m_if.ovf), 0);
        rst_n = 1'b1;
        send_uniform(3, 1'b0);
        idle(2);
        check_val("lat_valid_early", longint'(m_if.tree_valid), 0);
        idle(1);
        check_val("lat_tree_dout",  longint'($signed(m_if.tree_dout)), 30);
        check_val("lat_tree_valid", longint'(m_if.tree_valid), 1);
        idle(1);
        check_val("lat_acc_valid", longint'(m_if.acc_valid), 1);
        check_val("lat_acc_dout",  longint'($signed(m_if.acc_dout)), 30);

        // Signed extremes, one sample per frame
        send_alt();
        idle(3);
        check_val("alt_tree_dout", longint'($signed(m_if.tree_dout)), -5);
        idle(1);
        check_val("alt_acc_dout", longint'($signed(m_if.acc_dout)), -5);
        send_uniform(-128, 1'b0);
        idle(3);
        check_val("min_tree_dout", longint'($signed(m_if.tree_dout)), -1280);
        check_val("min_acc_valid_early", longint'(m_if.acc_valid), 0);
        idle(1);
        check_val("min_acc_valid", longint'(m_if.acc_valid), 1);
        check_val("min_acc_dout",  longint'($signed(m_if.acc_dout)), -1280);
        idle(2);

        // Frame dumps of four samples, contiguous then with gaps
        acc_len = 16'd4;
        clear_dumps();
        for (int i = 0; i < 8; i++) send_uniform(1, i == 0);
        idle(6);
        check_val("frame_count", q_main.size(), 2);
        if (q_main.size() == 2) begin
            check_val("frame0_total", q_main[0].val, 40);
            check_val("frame1_total", q_main[1].val, 40);
            check_val("frame_spacing", q_main[1].cyc - q_main[0].cyc, 4);
            check_val("frame_ovf", q_main[1].ovf, 0);
        end
        clear_dumps();
        for (int i = 0; i < 8; i++) begin
            send_uniform(1, i == 0);
            if (i % 3 == 1) idle(2);
        end
        idle(6);
        check_val("gap_count", q_main.size(), 2);
        if (q_main.size() == 2) begin
            check_val("gap0_total", q_main[0].val, 40);
            check_val("gap1_total", q_main[1].val, 40);
        end

        // Mid-frame sync drops the partial frame
        clear_dumps();
        send_uniform(10, 1'b0);
        send_uniform(10, 1'b0);
        send_uniform(1, 1'b1);
        send_uniform(2, 1'b0);
        send_uniform(3, 1'b0);
        send_uniform(4, 1'b0);
        idle(6);
        check_val("msync_count", q_main.size(), 1);
        if (q_main.size() == 1) check_val("msync_total", q_main[0].val, 100);

        // Overflow: saturate vs wrap, then a clean frame
        clear_dumps();
        for (int i = 0; i < 4; i++) send_uniform(127, i == 0);
        idle(6);
        for (int i = 0; i < 4; i++) send_uniform(1, i == 0);
        idle(6);
        check_val("sat_count",  q_sat.size(), 2);
        check_val("wrap_count", q_wrap.size(), 2);
        check_val("wide_count", q_main.size(), 2);
        if (q_sat.size() == 2) begin
            check_val("sat_total",   q_sat[0].val, 2047);
            check_val("sat_ovf",     q_sat[0].ovf, 1);
            check_val("sat_clean",   q_sat[1].val, 40);
            check_val("sat_ovf_clr", q_sat[1].ovf, 0);
        end
        if (q_wrap.size() == 2) begin
            check_val("wrap_total",   q_wrap[0].val, 984);
            check_val("wrap_ovf",     q_wrap[0].ovf, 1);
            check_val("wrap_ovf_clr", q_wrap[1].ovf, 0);
        end
        if (q_main.size() == 2) begin
            check_val("wide_total", q_main[0].val, 5080);
            check_val("wide_ovf",   q_main[0].ovf, 0);
        end

        // Reset mid-frame discards the partial
        clear_dumps();
        send_uniform(5, 1'b1);
        send_uniform(5, 1'b0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) send_uniform(i, 1'b0);
        idle(6);
        check_val("mrst_count", q_main.size(), 1);
        if (q_main.size() == 1) check_val("mrst_total", q_main[0].val, 100);
        check_val("mrst_p1_count", q_p1.size(), 1);
        if (q_p1.size() == 1) check_val("mrst_p1_total", q_p1[0].val, 10);

        // Single unsigned lane, acc_len of zero behaves as one
        acc_len = 16'd0;
        send_uniform(255, 1'b0);
        check_val("p1_tree_dout",  longint'(p_if.tree_dout), 255);
        check_val("p1_tree_valid", longint'(p_if.tree_valid), 1);
        idle(1);
        check_val("p1_acc_valid", longint'(p_if.acc_valid), 1);
        check_val("p1_acc_dout",  longint'(p_if.acc_dout), 255);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/adder_tree_acc.md
Name: adder_tree_acc

Overview:
- Parametrised successor to the team's pipelined adder tree.
- Reduces PARALLEL lanes per cycle to one registered sum, with selectable signed/unsigned arithmetic and a synchronous reset on every pipeline stage.
- Feeds that sum into a frame integrator that accumulates a run-time-programmable number of valid samples, then dumps the total.
- Sits after the per-lane power/correlation products in the DoA band chain.

Parameters:
- DATA_WIDTH, 8: width of each input lane.
- PARALLEL, 10: number of input lanes, 1 or more.
- SIGNED, 1: 1 = two's-complement lanes and sums; 0 = unsigned.
- ACC_WIDTH, 32: accumulator/output width; must be at least TW = DATA_WIDTH + $clog2(PARALLEL).
- LEN_WIDTH, 16: width of acc_len.
- SATURATE, 1: 1 = clamp accumulator on overflow; 0 = wrap.

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: synchronous reset, active-low.
- din, in, DATA_WIDTH*PARALLEL: lane k at din[k*DATA_WIDTH +: DATA_WIDTH].
- in_valid, in, 1: din qualifier.
- sync_in, in, 1: frame restart, aligned with din.
- acc_len, in, LEN_WIDTH: samples per frame; 0 is treated as 1.
- tree_dout, out, TW: registered lane sum.
- tree_valid, out, 1: tree_dout qualifier.
- acc_dout, out, ACC_WIDTH: frame total.
- acc_valid, out, 1: one-cycle dump strobe.
- ovf, out, 1: overflow occurred in the dumped frame; valid with acc_valid.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all outputs to 0, plus every pipeline data/valid/sync register, the counter and the accumulator.
- Reset mid-frame discards in-flight samples and the partial sum. The first frame after reset starts on the next tree_valid.
- Tree:
  - Pairwise reduction; each stage adds pairs and registers the result; an odd leftover lane is registered unchanged (sign/zero-extended).
  - Latency L = $clog2(PARALLEL) cycles, except PARALLEL=1, where L = 1 (single register).
  - Width grows 1 bit per stage. SIGNED selects sign- vs zero-extension.
  - in_valid and sync_in travel through an L-deep shift register, so tree_valid and the internal sync are aligned with tree_dout.
  - Data registers update every cycle regardless of valid.
- Integrator: state held in cnt (LEN_WIDTH bits), len_r and acc. The frame-start condition is cnt==0.
  - On tree_valid with cnt==0:
    - len_r <= max(acc_len, 1), latched once per frame; acc_len changes mid-frame take effect next frame.
    - acc <= ext(tree_dout), where ext is sign/zero extension to ACC_WIDTH.
    - The overflow flag is cleared.
  - On tree_valid with cnt>0: acc <= acc + ext(tree_dout).
  - The sample that makes cnt == len_r-1 is the last one. The next cycle, acc_dout = final total, acc_valid = 1 for one cycle, ovf = frame flag, and cnt returns to 0. Dump latency from the last din is therefore L+1 cycles.
  - acc_dout holds its value between dumps.
  - With len_r==1, every tree sample dumps; back-to-back valids give back-to-back acc_valid.
  - No tree_valid: state holds.
- Sync at tree output:
  - With tree_valid: the sample becomes the first of a new frame (cnt==0 path). The partial frame is dropped and no acc_valid is produced for it.
  - Without tree_valid: cnt <= 0 and the partial is dropped.
  - Sync coinciding with a last sample: the sample is treated as the first of a new frame, and no dump occurs.
- Overflow:
  - Detected on each add: signed mode when the result sign differs from both equal operand signs; unsigned mode on carry out.
  - SATURATE=1: clamp to the signed max/min (unsigned: all ones).
  - SATURATE=0: wrap.
  - The frame flag is sticky until the next frame start.

Test Plan:
- Reset/latency, PARALLEL=10, DATA_WIDTH=8, SIGNED=1: hold rst_n=0 for 3 cycles, then all lanes = 3 with in_valid=1 for one cycle -> tree_dout = 30 and tree_valid = 1 exactly 4 cycles later. All outputs are 0 during reset.
- Signed extremes, acc_len=1: lanes alternate -128/127 -> tree_dout = -5. All lanes -128 -> -1280 and acc_dout = -1280, with acc_valid 5 cycles after the input.
- Frame dump: acc_len=4, sync pulse with the first valid, 8 valid cycles of lanes = 1 -> two acc_valid pulses, each acc_dout = 40, 4 tree samples apart. Insert idle gaps in the valids -> totals unchanged.
- Mid-frame sync: acc_len=4, 2 valids of 10, then sync with a valid -> no dump for the partial. The next dump equals the sum of the 4 samples starting at the sync.
- Saturation: ACC_WIDTH=12, SATURATE=1, acc_len=4, lanes all 127 (sum 1270) -> acc_dout = 2047, ovf = 1. With SATURATE=0 -> wrapped value 5080 mod 4096 = 984, ovf = 1. The next non-overflowing frame gives ovf = 0.
- Reset mid-frame and PARALLEL=1/SIGNED=0: rst_n low after 2 of 4 samples, then 4 fresh samples -> exactly one dump, with only the post-reset total. For PARALLEL=1, din=255 unsigned -> tree_dout = 255 after 1 cycle.
